// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
// Holds the handshake state encoding, the default LED address and the out-of-range read value.
package dmem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam logic [15:0] DEFAULT_LED_ADDR = 16'hF000;
   localparam logic [15:0] OOR_DATA         = 16'hDEAD;

endpackage

// File: rtl/data_mem_responder_if.sv
// Processor data-bus handshake between a CPU (master) and the data memory responder (slave).
interface data_mem_responder_if;

   logic [15:0] DataAddr;
   logic [15:0] DataOut;
   logic        WriteData;
   logic        ReadData;
   logic [15:0] DataIn;
   logic        DataWaitreq;

   modport master (
      output DataAddr, DataOut, WriteData, ReadData,
      input  DataIn, DataWaitreq
   );

   modport slave (
      input  DataAddr, DataOut, WriteData, ReadData,
      output DataIn, DataWaitreq
   );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, DEPTH x 16, with one write enable and a registered read port.
// Contents are never reset; the read register only loads when a read is enabled.
module dmem_ram #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: inserts WAIT_CYCLES stall cycles per access, then serves RAM,
// a memory-mapped LED register or a fixed out-of-range word, and flags protocol misuse.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter int          DEPTH       = 4096,
   parameter logic [15:0] LED_ADDR    = DEFAULT_LED_ADDR
) (
   input  logic                  Clock,
   input  logic                  Reset,
   data_mem_responder_if.slave   bus,
   output logic [9:0]            LEDR,
   output logic                  ProtoErr
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [16:0] DEPTH_L   = 17'(DEPTH);
   localparam logic        HAS_WAITS = (WAIT_CYCLES != 0);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic        proto_err_q, proto_err_d;
   logic [9:0]  led_q, led_d;
   logic [15:0] data_in_q, data_in_d;
   logic        sel_ram_q, sel_ram_d;

   logic        req;
   logic        waitreq;
   logic        accept;
   logic        is_write;
   logic        is_read;
   logic        in_ram;
   logic        is_led;
   logic [15:0] ram_rdata;

   // Stall is combinational and forced low while reset is held so nothing is accepted then.
   always_comb begin
      req      = bus.ReadData | bus.WriteData;
      is_write = bus.WriteData;
      is_read  = bus.ReadData & ~bus.WriteData;
      in_ram   = ({1'b0, bus.DataAddr} < DEPTH_L);
      is_led   = (bus.DataAddr == LED_ADDR);
      if (state_q == IDLE) begin
         waitreq = req & HAS_WAITS;
      end else begin
         waitreq = req & (cnt_q != 4'd0);
      end
      waitreq = waitreq & Reset;
      accept  = req & ~waitreq & Reset;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      proto_err_d = proto_err_q;
      led_d       = led_q;
      data_in_d   = data_in_q;
      sel_ram_d   = sel_ram_q;

      case (state_q)
         IDLE: begin
            if (req && HAS_WAITS) begin
               state_d = WAIT;
               cnt_d   = 4'(WAIT_CYCLES - 1);
               addr_d  = bus.DataAddr;
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
            end
            if (req && (bus.DataAddr != addr_q)) begin
               proto_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.ReadData && bus.WriteData) begin
         proto_err_d = 1'b1;
      end

      if (accept && is_write && !in_ram && is_led) begin
         led_d = bus.DataOut[9:0];
      end

      // RAM reads come straight from the RAM's read register; other reads are held here.
      if (accept && is_read) begin
         sel_ram_d = in_ram;
         if (!in_ram) begin
            data_in_d = is_led ? {6'b0, led_q} : OOR_DATA;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= 16'h0000;
         proto_err_q <= 1'b0;
         led_q       <= 10'h000;
         data_in_q   <= 16'h0000;
         sel_ram_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         proto_err_q <= proto_err_d;
         led_q       <= led_d;
         data_in_q   <= data_in_d;
         sel_ram_q   <= sel_ram_d;
      end
   end

   dmem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (Clock),
      .we    (accept & is_write & in_ram),
      .re    (accept & is_read & in_ram),
      .addr  (bus.DataAddr[AW-1:0]),
      .wdata (bus.DataOut),
      .rdata (ram_rdata)
   );

   assign bus.DataWaitreq = waitreq;
   assign bus.DataIn      = sel_ram_q ? ram_rdata : data_in_q;
   assign LEDR            = led_q;
   assign ProtoErr        = proto_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait cycles, one with none,
// driven by directed and random accesses and checked against a transaction-level model.
module tb_data_mem_responder;
   import dmem_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [9:0] ledr_a, ledr_b;
   logic       err_a, err_b;

   int checks = 0;
   int fails  = 0;

   data_mem_responder_if bus_a ();
   data_mem_responder_if bus_b ();

   data_mem_responder #(.WAIT_CYCLES(2)) dut_a (
      .Clock    (Clock),
      .Reset    (Reset),
      .bus      (bus_a),
      .LEDR     (ledr_a),
      .ProtoErr (err_a)
   );

   data_mem_responder #(.WAIT_CYCLES(0)) dut_b (
      .Clock    (Clock),
      .Reset    (Reset),
      .bus      (bus_b),
      .LEDR     (ledr_b),
      .ProtoErr (err_b)
   );

   always #5 Clock = ~Clock;

   // Model state: index 0 is the two-wait instance, index 1 the zero-wait instance.
   logic [15:0] mem_m [2][4096];
   logic [9:0]  led_m [2];
   logic        err_m [2];
   logic [15:0] din_m [2];
   int          waits [2] = '{2, 0};

   task automatic check_output(string tag, logic [15:0] obs, logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(int s, bit rd, bit wr, logic [15:0] addr, logic [15:0] wd);
      if (s == 0) begin
         bus_a.ReadData = rd; bus_a.WriteData = wr; bus_a.DataAddr = addr; bus_a.DataOut = wd;
      end else begin
         bus_b.ReadData = rd; bus_b.WriteData = wr; bus_b.DataAddr = addr; bus_b.DataOut = wd;
      end
   endtask

   function automatic logic get_wait(int s);
      return (s == 0) ? bus_a.DataWaitreq : bus_b.DataWaitreq;
   endfunction

   function automatic logic [15:0] get_din(int s);
      return (s == 0) ? bus_a.DataIn : bus_b.DataIn;
   endfunction

   function automatic logic [9:0] get_led(int s);
      return (s == 0) ? ledr_a : ledr_b;
   endfunction

   function automatic logic get_err(int s);
      return (s == 0) ? err_a : err_b;
   endfunction

   function automatic void model_apply(int s, bit rd, bit wr, logic [15:0] addr, logic [15:0] wd);
      if (rd && wr) err_m[s] = 1'b1;
      if (wr) begin
         if (addr < 16'd4096) mem_m[s][addr[11:0]] = wd;
         else if (addr == 16'hF000) led_m[s] = wd[9:0];
      end else if (rd) begin
         if (addr < 16'd4096) din_m[s] = mem_m[s][addr[11:0]];
         else if (addr == 16'hF000) din_m[s] = {6'b0, led_m[s]};
         else din_m[s] = 16'hDEAD;
      end
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < 2; s++) begin
         led_m[s] = '0; err_m[s] = 1'b0; din_m[s] = '0;
      end
   endfunction

   task automatic check_regs(int s, string tag);
      check_output({tag, ":DataIn"}, get_din(s), din_m[s]);
      check_output({tag, ":LEDR"}, 16'(get_led(s)), 16'(led_m[s]));
      check_output({tag, ":ProtoErr"}, 16'(get_err(s)), 16'(err_m[s]));
   endtask

   // One complete access: count stall cycles, let it be accepted, then compare with the model.
   task automatic apply_stimulus(int s, bit rd, bit wr, logic [15:0] addr, logic [15:0] wd, string tag);
      int stalls = 0;
      @(negedge Clock);
      drive(s, rd, wr, addr, wd);
      #1;
      while (get_wait(s) && stalls <= 20) begin
         stalls++;
         @(negedge Clock);
         #1;
      end
      check_output({tag, ":stalls"}, 16'(stalls), 16'(waits[s]));
      @(posedge Clock);
      #1;
      drive(s, 1'b0, 1'b0, addr, wd);
      model_apply(s, rd, wr, addr, wd);
      check_regs(s, tag);
   endtask

   task automatic pulse_reset();
      @(negedge Clock);
      Reset = 1'b0;
      model_reset();
      @(negedge Clock);
      Reset = 1'b1;
   endtask

   initial begin
      logic [15:0] a;
      logic [15:0] d;
      int          s;
      int          op;

      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
      model_reset();
      #1;
      check_output("reset:waitreq", 16'(bus_a.DataWaitreq), 16'h0);
      check_regs(0, "reset_a");
      check_regs(1, "reset_b");
      repeat (2) @(negedge Clock);
      Reset = 1'b1;

      for (int i = 0; i < 32; i++) begin
         apply_stimulus(0, 1'b0, 1'b1, 16'(i), 16'($urandom), "init_a");
         apply_stimulus(1, 1'b0, 1'b1, 16'(i), 16'($urandom), "init_b");
      end

      apply_stimulus(0, 1'b0, 1'b1, 16'h0010, 16'h1234, "wr_0010");
      apply_stimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000, "rd_0010");
      apply_stimulus(1, 1'b1, 1'b0, 16'h0000, 16'h0000, "b2b_rd0");
      apply_stimulus(1, 1'b1, 1'b0, 16'h0001, 16'h0000, "b2b_rd1");
      apply_stimulus(0, 1'b0, 1'b1, 16'hF000, 16'h03FF, "wr_led");
      apply_stimulus(0, 1'b1, 1'b0, 16'hF000, 16'h0000, "rd_led");
      apply_stimulus(0, 1'b1, 1'b0, 16'h2000, 16'h0000, "rd_oor");
      apply_stimulus(0, 1'b0, 1'b1, 16'h2000, 16'h5A5A, "wr_oor");
      apply_stimulus(0, 1'b1, 1'b0, 16'h0000, 16'h0000, "rd_0000_after_oor");
      apply_stimulus(0, 1'b1, 1'b0, 16'hF000, 16'h0000, "rd_led_after_oor");

      // Address moves while stalled: flagged, and the address at acceptance wins.
      @(negedge Clock);
      drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      @(negedge Clock);
      drive(0, 1'b1, 1'b0, 16'h0011, 16'h0000);
      #1;
      check_output("addr_chg:stall", 16'(bus_a.DataWaitreq), 16'h1);
      @(negedge Clock);
      #1;
      check_output("addr_chg:go", 16'(bus_a.DataWaitreq), 16'h0);
      @(posedge Clock);
      #1;
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      err_m[0] = 1'b1;
      din_m[0] = mem_m[0][17];
      check_regs(0, "addr_chg");

      pulse_reset();
      apply_stimulus(0, 1'b1, 1'b1, 16'h0005, 16'hBEEF, "both_high");
      apply_stimulus(0, 1'b1, 1'b0, 16'h0005, 16'h0000, "rd_after_both");

      // Request dropped mid-stall: no write happens.
      @(negedge Clock);
      drive(0, 1'b0, 1'b1, 16'h0006, 16'h5555);
      #1;
      check_output("abort:stall", 16'(bus_a.DataWaitreq), 16'h1);
      @(negedge Clock);
      drive(0, 1'b0, 1'b0, 16'h0006, 16'h5555);
      @(negedge Clock);
      #1;
      check_output("abort:idle", 16'(bus_a.DataWaitreq), 16'h0);
      apply_stimulus(0, 1'b1, 1'b0, 16'h0006, 16'h0000, "abort_rd");

      // Reset asserted mid-stall clears everything at once but keeps the RAM.
      apply_stimulus(0, 1'b0, 1'b1, 16'hF000, 16'h02A5, "led_again");
      @(negedge Clock);
      drive(0, 1'b0, 1'b1, 16'h0007, 16'h7777);
      @(negedge Clock);
      Reset = 1'b0;
      model_reset();
      #1;
      check_output("rst_mid:waitreq", 16'(bus_a.DataWaitreq), 16'h0);
      check_regs(0, "rst_mid");
      @(negedge Clock);
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      Reset = 1'b1;
      apply_stimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000, "rd_after_rst");
      apply_stimulus(0, 1'b1, 1'b0, 16'h0007, 16'h0000, "rd_unwritten_7");

      for (int n = 0; n < 160; n++) begin
         s  = int'($urandom_range(1, 0));
         op = int'($urandom_range(7, 0));
         case ($urandom_range(3, 0))
            0:       a = 16'hF000;
            1:       a = 16'h2000 + 16'($urandom_range(255, 0));
            default: a = 16'($urandom_range(31, 0));
         endcase
         d = 16'($urandom);
         if (op == 0) apply_stimulus(s, 1'b1, 1'b1, a, d, "rand_both");
         else if (op < 4) apply_stimulus(s, 1'b0, 1'b1, a, d, "rand_wr");
         else apply_stimulus(s, 1'b1, 1'b0, a, d, "rand_rd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of DataWaitreq-high cycles inserted before each transfer is accepted (0..15).
REQ-002 Parameter DEPTH, default 4096, number of 16-bit RAM words.
REQ-003 Parameter LED_ADDR, default 16'hF000, address of the memory-mapped LED register.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Clock  input  1  rising-edge clock.
REQ-006 Reset  input  1  asynchronous reset, active-low.
REQ-007 DataAddr  input  16  word address from the processor.
REQ-008 DataOut  input  16  write data from the processor.
REQ-009 WriteData  input  1  write request.
REQ-010 ReadData  input  1  read request.
REQ-011 DataIn  output  16  registered read data to the processor.
REQ-012 DataWaitreq  output  1  stall; the request is held while this is high.
REQ-013 LEDR  output  10  LED register contents.
REQ-014 ProtoErr  output  1  sticky protocol-violation flag.

Function
REQ-015 The states SHALL be IDLE and WAIT, with a 4-bit down-counter cnt.
- Request: req = ReadData | WriteData.
REQ-016 DataWaitreq SHALL be combinational:
- In IDLE: req && (WAIT_CYCLES != 0).
- In WAIT: req && (cnt != 0).
REQ-017 Acceptance SHALL occur at a rising edge where req=1 and DataWaitreq=0.
REQ-018 IDLE with req and WAIT_CYCLES > 0 SHALL go to WAIT with cnt = WAIT_CYCLES-1 and latch DataAddr.
- Result: exactly WAIT_CYCLES stall cycles precede acceptance.
REQ-019 In WAIT, cnt SHALL decrement each cycle while req=1; acceptance returns the state to IDLE.
REQ-020 If req drops in WAIT, the block SHALL return to IDLE with no memory or LED side effect (abort).
REQ-021 A write SHALL commit at the acceptance edge:
- DataAddr < DEPTH: to RAM.
- DataAddr = LED_ADDR: to LEDR (DataOut[9:0]).
- Otherwise: dropped.
REQ-022 For a read, DataIn SHALL update one cycle after acceptance (latency 1) and hold until the next accepted read:
- DataAddr < DEPTH: RAM word.
- DataAddr = LED_ADDR: {6'b0, LEDR}.
- Otherwise: 16'hDEAD.
REQ-023 ReadData and WriteData both high SHALL be treated as a write and set ProtoErr.
REQ-024 A DataAddr change while in WAIT SHALL set ProtoErr; the address at the acceptance edge is used.
REQ-025 ProtoErr SHALL stay set until reset.
REQ-026 Back-to-back requests: a request present in the cycle after acceptance SHALL start a fresh wait count from IDLE.
REQ-027 A read-after-write to the same address SHALL return the newly written data.

Reset
REQ-028 Reset low SHALL immediately force:
- state IDLE, cnt 0;
- DataIn 16'h0000, LEDR 0, ProtoErr 0;
- DataWaitreq 0.
REQ-029 Reset SHALL NOT clear RAM contents.
REQ-030 Reset mid-transfer SHALL abort the transfer with no side effect.

Structure
REQ-031 A shared package dmem_pkg SHALL hold:
- the state enum {IDLE, WAIT};
- default LED_ADDR;
- OOR_DATA = 16'hDEAD.
REQ-032 RAM SHALL be a sub-module dmem_ram: single-port synchronous, DEPTH x 16, one write enable, registered read.

Verification
REQ-033 WAIT_CYCLES=2, write 16'h1234 to 0x0010, then read 0x0010 -> DataWaitreq high 2 cycles per access; DataIn=16'h1234 one cycle after read acceptance.
REQ-034 WAIT_CYCLES=0, back-to-back reads of 0x0000 and 0x0001 -> DataWaitreq never high; DataIn follows with 1-cycle latency each.
REQ-035 Write 16'h03FF to 0xF000, read 0xF000 -> LEDR=10'h3FF; DataIn=16'h03FF.
REQ-036 Read 0x2000 (>= DEPTH) -> DataIn=16'hDEAD; write to 0x2000 leaves RAM and LEDR unchanged.
REQ-037 ReadData=WriteData=1 -> write performed, ProtoErr=1; drop req mid-WAIT -> no write, back to IDLE.
REQ-038 Assert Reset during WAIT -> DataWaitreq=0, LEDR=0, ProtoErr=0 immediately; earlier RAM data still readable after reset.
